// File: rtl/count_seq_ctrl_if.sv
// Board-side signal bundle for the LED count controller: buttons and direction
// switch in, count/tick/state out.
interface count_seq_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             KEY_RUN;
    logic             KEY_CLR;
    logic             SW_DIR;
    logic [WIDTH-1:0] LED;
    logic             tick;
    logic [1:0]       state;

    modport master (
        output KEY_RUN, KEY_CLR, SW_DIR,
        input  LED, tick, state
    );

    modport slave (
        input  KEY_RUN, KEY_CLR, SW_DIR,
        output LED, tick, state
    );
endinterface

// File: rtl/count_seq_ctrl.sv
// Run/pause/clear controller for the LED counter: synchronises and debounces the
// buttons, runs IDLE/RUN/PAUSE, and steps a wrapping up/down count at TICK_HZ.
module count_seq_ctrl #(
    parameter int CLK_HZ       = 50000000,
    parameter int TICK_HZ      = 1,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int MAX_COUNT    = 8,
    parameter int WIDTH        = 4
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    count_seq_ctrl_if.slave   bus
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = $clog2(DIV);
    localparam int DB_W  = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    // Index 0 is the run button, index 1 the clear button.
    logic [1:0]       key_s1, key_s2;
    logic [1:0]       key_deb, key_deb_d;
    logic [DB_W-1:0]  db_cnt [2];
    logic             dir_s1, dir_s2;
    logic             run_press, clr_press;

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q;
    logic [WIDTH-1:0] count_q;
    logic             tick_q;
    logic             wrap;

    function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] c,
                                                    input logic             down);
        if (c > WIDTH'(MAX_COUNT))
            return '0;
        if (down)
            return (c == '0) ? WIDTH'(MAX_COUNT) : c - 1'b1;
        return (c == WIDTH'(MAX_COUNT)) ? '0 : c + 1'b1;
    endfunction

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            key_s1 <= 2'b11;
            key_s2 <= 2'b11;
            dir_s1 <= 1'b1;
            dir_s2 <= 1'b1;
        end else begin
            key_s1 <= {bus.KEY_CLR, bus.KEY_RUN};
            key_s2 <= key_s1;
            dir_s1 <= bus.SW_DIR;
            dir_s2 <= dir_s1;
        end
    end

    // A level is accepted only after DEBOUNCE_CYC consecutive differing samples.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            key_deb   <= 2'b11;
            key_deb_d <= 2'b11;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (key_s2[i] == key_deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    key_deb[i] <= key_s2[i];
                    db_cnt[i]  <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
            key_deb_d <= key_deb;
        end
    end

    assign run_press = key_deb_d[0] & ~key_deb[0];
    assign clr_press = key_deb_d[1] & ~key_deb[1];

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (run_press) state_d = RUN;
            RUN:     if (run_press) state_d = PAUSE;
            PAUSE:   if (run_press) state_d = RUN;
            default: state_d = IDLE;
        endcase
        if (clr_press)
            state_d = IDLE;
    end

    assign wrap = (state_q == RUN) && (pre_q == PRE_W'(DIV - 1));

    // The update on a wrap edge uses the current state, so a run press on
    // that edge still lets the tick through before pausing.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            pre_q   <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (clr_press) begin
                pre_q   <= '0;
                count_q <= '0;
            end else if (wrap) begin
                pre_q   <= '0;
                tick_q  <= 1'b1;
                count_q <= next_count(count_q, dir_s2);
            end else if (state_q == RUN) begin
                pre_q <= pre_q + 1'b1;
            end else if (state_q == IDLE) begin
                pre_q <= '0;
            end
        end
    end

    assign bus.LED   = count_q;
    assign bus.tick  = tick_q;
    assign bus.state = state_q;

endmodule
